// File: rtl/pixel_stream_pkg.sv
// Shared geometry, state encoding and buffer addressing for the CHIP pixel-load transmitter.
// Pure declarations: no latency, no flow control.
package pixel_stream_pkg;

  localparam int PIX_W   = 5;
  localparam int IMG_W   = 20;
  localparam int IMG_H   = 20;
  localparam int LANES   = 5;
  localparam int OUT_CNT = (IMG_W - 2) * (IMG_H - 2);

  localparam int NPIX   = IMG_W * IMG_H;
  localparam int NGRP   = IMG_H / LANES;
  localparam int ADDR_W = $clog2(NPIX);
  localparam int COL_W  = $clog2(IMG_W);
  localparam int GRP_W  = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam int CNT_W  = $clog2(OUT_CNT + 1);

  localparam logic [COL_W-1:0]  LAST_COL = COL_W'(IMG_W - 1);
  localparam logic [COL_W-1:0]  PEN_COL  = COL_W'(IMG_W - 2);
  localparam logic [GRP_W-1:0]  LAST_GRP = GRP_W'(NGRP - 1);
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NPIX - 1);
  localparam logic [CNT_W-1:0]  OUT_LAST = CNT_W'(OUT_CNT - 1);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_e;

  typedef logic [PIX_W-1:0] pix_t;
  typedef logic [LANES-1:0][PIX_W-1:0] lanes_t;

  // Lane k of a beat carries row (group*LANES + k) at the beat's column.
  function automatic logic [ADDR_W-1:0] rd_addr(input logic [GRP_W-1:0] grp,
                                                input logic [COL_W-1:0] col,
                                                input int lane);
    return ADDR_W'((int'(grp) * LANES + lane) * IMG_W + int'(col));
  endfunction

endpackage

// File: rtl/pixel_frame_buf.sv
// Frame store: one synchronous write port, LANES combinational read ports per (group, col).
// Write lands on the next edge, reads are same-cycle; no backpressure, caller sequences access.
module pixel_frame_buf
  import pixel_stream_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  pix_t              i_wr_dat,
  input  logic [GRP_W-1:0]  i_rd_grp,
  input  logic [COL_W-1:0]  i_rd_col,
  output lanes_t            o_rd_dat
);

  pix_t r_mem [NPIX];

  // Contents survive reset; every frame rewrites all entries before they are read.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_wr_addr] <= i_wr_dat;
    end
  end

  always_comb begin
    o_rd_dat = '0;
    for (int k = 0; k < LANES; k++) begin
      o_rd_dat[k] = r_mem[rd_addr(i_rd_grp, i_rd_col, k)];
    end
  end

endmodule

// File: rtl/pixel_stream_tx.sv
// Host-side CHIP loader: buffers a raster frame, streams it as LANES-wide beats, then waits out the result window.
// Beat 0 is registered out the cycle after the last accept; in_ready is low outside FILL, CHIP side has no backpressure.
module pixel_stream_tx
  import pixel_stream_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [PIX_W-1:0] in_pixel,
  output logic             in_ready,
  output logic [PIX_W-1:0] pixel_in0,
  output logic [PIX_W-1:0] pixel_in1,
  output logic [PIX_W-1:0] pixel_in2,
  output logic [PIX_W-1:0] pixel_in3,
  output logic [PIX_W-1:0] pixel_in4,
  output logic             load_end,
  input  logic             readable,
  output logic             frame_done,
  output logic             busy
);

  state_e            r_state;
  logic [ADDR_W-1:0] r_wr_cnt;
  logic [COL_W-1:0]  r_col;
  logic [GRP_W-1:0]  r_grp;
  logic [CNT_W-1:0]  r_rd_cnt;
  lanes_t            r_lanes;
  logic              r_load_end;

  logic              w_accept;
  logic              w_last_beat;
  logic              w_nxt_le;
  logic [COL_W-1:0]  w_nxt_col;
  logic [GRP_W-1:0]  w_nxt_grp;
  lanes_t            w_rd_lanes;

  assign in_ready    = (r_state == FILL);
  assign busy        = (r_state != FILL);
  assign w_accept    = in_valid && in_ready;
  assign w_last_beat = (r_grp == LAST_GRP) && (r_col == LAST_COL);
  assign w_nxt_le    = (w_nxt_grp == LAST_GRP) && (w_nxt_col == PEN_COL);
  assign frame_done  = (r_state == DRAIN) && readable && (r_rd_cnt == OUT_LAST);

  // The read port always addresses the beat to be registered on the next edge.
  always_comb begin
    w_nxt_col = '0;
    w_nxt_grp = '0;
    if (r_state == STREAM) begin
      if (r_col == LAST_COL) begin
        w_nxt_grp = r_grp + 1'b1;
      end else begin
        w_nxt_grp = r_grp;
        w_nxt_col = r_col + 1'b1;
      end
    end
  end

  pixel_frame_buf u_buf (
    .i_clk     (clk),
    .i_we      (w_accept),
    .i_wr_addr (r_wr_cnt),
    .i_wr_dat  (in_pixel),
    .i_rd_grp  (w_nxt_grp),
    .i_rd_col  (w_nxt_col),
    .o_rd_dat  (w_rd_lanes)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= FILL;
      r_wr_cnt   <= '0;
      r_col      <= '0;
      r_grp      <= '0;
      r_rd_cnt   <= '0;
      r_lanes    <= '0;
      r_load_end <= 1'b0;
    end else begin
      case (r_state)
        FILL: begin
          if (w_accept) begin
            if (r_wr_cnt == LAST_PIX) begin
              r_state  <= STREAM;
              r_wr_cnt <= '0;
              r_lanes  <= w_rd_lanes;
              r_col    <= w_nxt_col;
              r_grp    <= w_nxt_grp;
            end else begin
              r_wr_cnt <= r_wr_cnt + 1'b1;
            end
          end
        end
        STREAM: begin
          if (w_last_beat) begin
            r_state <= DRAIN;
            r_lanes <= '0;
            r_col   <= '0;
            r_grp   <= '0;
          end else begin
            r_lanes <= w_rd_lanes;
            r_col   <= w_nxt_col;
            r_grp   <= w_nxt_grp;
            if (w_nxt_le) begin
              r_load_end <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (readable) begin
            if (r_rd_cnt == OUT_LAST) begin
              r_state    <= FILL;
              r_rd_cnt   <= '0;
              r_load_end <= 1'b0;
            end else begin
              r_rd_cnt <= r_rd_cnt + 1'b1;
            end
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

  assign pixel_in0 = r_lanes[0];
  assign pixel_in1 = r_lanes[1];
  assign pixel_in2 = r_lanes[2];
  assign pixel_in3 = r_lanes[3];
  assign pixel_in4 = r_lanes[4];
  assign load_end  = r_load_end;

endmodule

// File: tb/tb_pixel_stream_tx.sv
// Scenario bench for pixel_stream_tx: frames are recorded as sent, expected beats queued, and popped as CHIP sees them.
module tb_pixel_stream_tx;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic [4:0] in_pixel;
  logic       in_ready;
  logic [4:0] p0, p1, p2, p3, p4;
  logic       load_end;
  logic       readable;
  logic       frame_done;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;
  bit pre_rd = 1'b0;

  typedef struct packed {
    logic [4:0] l0, l1, l2, l3, l4;
    logic       le;
  } beat_t;

  beat_t      q[$];
  logic [4:0] fr [400];

  always #5 clk = ~clk;

  pixel_stream_tx dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_pixel   (in_pixel),
    .in_ready   (in_ready),
    .pixel_in0  (p0),
    .pixel_in1  (p1),
    .pixel_in2  (p2),
    .pixel_in3  (p3),
    .pixel_in4  (p4),
    .load_end   (load_end),
    .readable   (readable),
    .frame_done (frame_done),
    .busy       (busy)
  );

  function automatic logic [4:0] pixval(input int kind, input int r, input int c);
    if (kind == 1) return 5'd31;
    return 5'((r + c) % 32);
  endfunction

  function automatic bit rd_sched(input int i);
    return !((i >= 100 && i < 105) || (i >= 255 && i < 258));
  endfunction

  task automatic test_reset();
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_pixel = '0;
    readable = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || busy !== 1'b0)
      begin n_bad++; $display("FAIL reset_release: in_ready=%b busy=%b, need 1 0", in_ready, busy); end
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({p0, p1, p2, p3, p4, load_end, frame_done, busy} !== 28'd0)
      begin n_bad++; $display("FAIL reset_outputs: got %h, need 0", {p0, p1, p2, p3, p4, load_end, frame_done, busy}); end
    n_cmp++;
    if (in_ready !== 1'b1)
      begin n_bad++; $display("FAIL reset_in_ready: got %b, need 1", in_ready); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Returns on the edge that accepts pixel 399, so the next negedge shows beat 0.
  task automatic test_fill(input int kind, input bit toggle);
    int n = 0;
    int cyc = 0;
    bit v;
    logic [4:0] px;
    beat_t e;
    while (n < 400 && cyc < 3000) begin
      @(posedge clk);
      #1;
      v = toggle ? (cyc % 2 == 0) : 1'b1;
      px = pixval(kind, n / 20, n % 20);
      in_valid = v;
      in_pixel = v ? px : 5'(cyc);
      readable = pre_rd;
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b1 || busy !== 1'b0)
        begin n_bad++; $display("FAIL fill_ready px%0d: in_ready=%b busy=%b, need 1 0", n, in_ready, busy); end
      if (v && in_ready === 1'b1) begin
        fr[n] = px;
        n++;
      end
      cyc++;
    end
    n_cmp++;
    if (n != 400)
      begin n_bad++; $display("FAIL fill_timeout: accepted %0d, need 400", n); end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_pixel = '0;
    for (int b = 0; b < 80; b++) begin
      e.l0 = fr[(5 * (b / 20) + 0) * 20 + b % 20];
      e.l1 = fr[(5 * (b / 20) + 1) * 20 + b % 20];
      e.l2 = fr[(5 * (b / 20) + 2) * 20 + b % 20];
      e.l3 = fr[(5 * (b / 20) + 3) * 20 + b % 20];
      e.l4 = fr[(5 * (b / 20) + 4) * 20 + b % 20];
      e.le = (b >= 78);
      q.push_back(e);
    end
  endtask

  task automatic test_stream(input int nbeats, input bit spot);
    beat_t e;
    logic [24:0] exp_s;
    for (int b = 0; b < nbeats; b++) begin
      @(negedge clk);
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++; $display("FAIL stream_queue beat%0d: queue empty, need an entry", b);
      end else begin
        e = q.pop_front();
        if ({p0, p1, p2, p3, p4} !== {e.l0, e.l1, e.l2, e.l3, e.l4})
          begin n_bad++; $display("FAIL beat%0d lanes: got %h, need %h", b, {p0, p1, p2, p3, p4}, {e.l0, e.l1, e.l2, e.l3, e.l4}); end
        n_cmp++;
        if (load_end !== e.le)
          begin n_bad++; $display("FAIL beat%0d load_end: got %b, need %b", b, load_end, e.le); end
      end
      n_cmp++;
      if (busy !== 1'b1 || in_ready !== 1'b0)
        begin n_bad++; $display("FAIL beat%0d busy/ready: got %b %b, need 1 0", b, busy, in_ready); end
      if (spot && (b == 0 || b == 21 || b == 79)) begin
        exp_s = (b == 0)  ? {5'd0, 5'd1, 5'd2, 5'd3, 5'd4} :
                (b == 21) ? {5'd6, 5'd7, 5'd8, 5'd9, 5'd10} :
                            {5'd2, 5'd3, 5'd4, 5'd5, 5'd6};
        n_cmp++;
        if ({p0, p1, p2, p3, p4} !== exp_s)
          begin n_bad++; $display("FAIL spot_beat%0d: got %h, need %h", b, {p0, p1, p2, p3, p4}, exp_s); end
      end
    end
    if (nbeats == 80) begin
      @(posedge clk);
      #1 readable = 1'b0;
    end
  endtask

  task automatic test_drain();
    int cnt = 0;
    int i = 0;
    bit r;
    bit exp_fd;
    @(negedge clk);
    n_cmp++;
    if ({p0, p1, p2, p3, p4} !== 25'd0 || load_end !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0)
      begin n_bad++; $display("FAIL drain_entry: lanes=%h le=%b busy=%b rdy=%b, need 0 1 1 0", {p0, p1, p2, p3, p4}, load_end, busy, in_ready); end
    while (cnt < 324 && i < 1000) begin
      r = rd_sched(i);
      @(posedge clk);
      #1 readable = r;
      @(negedge clk);
      exp_fd = r && (cnt == 323);
      n_cmp++;
      if (frame_done !== exp_fd)
        begin n_bad++; $display("FAIL drain_frame_done cyc%0d cnt%0d: got %b, need %b", i, cnt, frame_done, exp_fd); end
      n_cmp++;
      if (load_end !== 1'b1)
        begin n_bad++; $display("FAIL drain_load_end cyc%0d: got %b, need 1", i, load_end); end
      if (r) cnt++;
      i++;
    end
    @(posedge clk);
    #1 readable = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (load_end !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0)
      begin n_bad++; $display("FAIL drain_exit: le=%b rdy=%b busy=%b fd=%b, need 0 1 0 0", load_end, in_ready, busy, frame_done); end
    @(posedge clk);
    #1 readable = 1'b0;
  endtask

  task automatic test_reset_mid_stream();
    test_fill(0, 1'b0);
    test_stream(41, 1'b0);
    #1 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({p0, p1, p2, p3, p4, load_end, frame_done, busy} !== 28'd0 || in_ready !== 1'b1)
      begin n_bad++; $display("FAIL abort_outputs: got %h rdy=%b, need 0 rdy=1", {p0, p1, p2, p3, p4, load_end, frame_done, busy}, in_ready); end
    q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    test_fill(1, 1'b0);
    test_stream(80, 1'b0);
    test_drain();
  endtask

  initial begin
    test_reset();
    pre_rd = 1'b0;
    test_fill(0, 1'b0);
    test_stream(80, 1'b1);
    test_drain();
    pre_rd = 1'b1;
    test_fill(0, 1'b1);
    test_stream(80, 1'b1);
    test_drain();
    pre_rd = 1'b0;
    test_reset_mid_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
